// File: rtl/wb_write_arbiter.sv
// Write-back arbiter: merges pipeline and multiply/divide results onto one registered
// register-file write port. Optional conflict counter enabled by WB_CONFLICT_CNT_EN.
module wb_write_arbiter #(
    parameter int MD_FIFO_DEPTH = 2,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             pipe_valid_i,
    input  logic [4:0]                       pipe_rd_addr_i,
    input  logic [31:0]                      pipe_rd_data_i,
    input  logic                             md_valid_i,
    output logic                             md_ready_o,
    input  logic [4:0]                       md_rd_addr_i,
    input  logic [31:0]                      md_rd_data_i,
    output logic                             rf_write_en_o,
    output logic [4:0]                       rf_rd_addr_o,
    output logic [31:0]                      rf_rd_data_o,
`ifdef WB_CONFLICT_CNT_EN
    output logic [31:0]                      conflict_cnt_o,
`endif
    output logic                             stall_req_o,
    output logic [$clog2(MD_FIFO_DEPTH):0]   md_fifo_count_o
);

    localparam int PTR_W = $clog2(MD_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ST_W  = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MD_FIFO_DEPTH);
    localparam logic [ST_W-1:0]  ST_MAX   = ST_W'(STARVE_LIMIT);

    logic [36:0]      fifo_mem [MD_FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic [ST_W-1:0]  starve_q, starve_d;

    logic        pipe_win, fifo_nonempty, md_xfer, md_nz;
    logic        enq, deq, fall;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    assign md_ready_o      = (count_q != FULL_CNT);
    assign md_fifo_count_o = count_q;

    always_comb begin
        pipe_win      = pipe_valid_i && (pipe_rd_addr_i != 5'd0);
        fifo_nonempty = (count_q != '0);
        md_xfer       = md_valid_i && md_ready_o;
        md_nz         = md_rd_addr_i != 5'd0;
        deq           = !pipe_win && fifo_nonempty;
        // Bypass only with an empty FIFO so retirement order is kept.
        fall          = !pipe_win && !fifo_nonempty && md_xfer && md_nz;
        enq           = md_xfer && md_nz && !fall;
        count_d       = count_q + CNT_W'(enq) - CNT_W'(deq);

        starve_d = '0;
        if (fifo_nonempty && !deq)
            starve_d = (starve_q >= ST_MAX) ? ST_MAX : starve_q + 1'b1;

        wr_en   = pipe_win || deq || fall;
        wr_addr = md_rd_addr_i;
        wr_data = md_rd_data_i;
        if (pipe_win) begin
            wr_addr = pipe_rd_addr_i;
            wr_data = pipe_rd_data_i;
        end else if (fifo_nonempty) begin
            wr_addr = fifo_mem[rd_ptr_q][36:32];
            wr_data = fifo_mem[rd_ptr_q][31:0];
        end
    end

    // FIFO storage carries data only; occupancy lives in the control registers.
    always_ff @(posedge clk_i) begin
        if (enq)
            fifo_mem[wr_ptr_q] <= {md_rd_addr_i, md_rd_data_i};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            starve_q      <= '0;
            stall_req_o   <= 1'b0;
            rf_write_en_o <= 1'b0;
            rf_rd_addr_o  <= 5'd0;
            rf_rd_data_o  <= 32'd0;
        end else begin
            if (enq)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (deq)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q       <= count_d;
            starve_q      <= starve_d;
            stall_req_o   <= (starve_d >= ST_MAX) || (count_d == FULL_CNT);
            rf_write_en_o <= wr_en;
            if (wr_en) begin
                rf_rd_addr_o <= wr_addr;
                rf_rd_data_o <= wr_data;
            end
        end
    end

`ifdef WB_CONFLICT_CNT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            conflict_cnt_o <= 32'd0;
        else if (pipe_win && fifo_nonempty && (conflict_cnt_o != 32'hFFFF_FFFF))
            conflict_cnt_o <= conflict_cnt_o + 32'd1;
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_ni)
            assert (!(rf_write_en_o && (rf_rd_addr_o == 5'd0)));
    end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter (default build, depth 2, starve limit 4).
module tb_wb_write_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        pipe_valid_i;
    logic [4:0]  pipe_rd_addr_i;
    logic [31:0] pipe_rd_data_i;
    logic        md_valid_i;
    logic        md_ready_o;
    logic [4:0]  md_rd_addr_i;
    logic [31:0] md_rd_data_i;
    logic        rf_write_en_o;
    logic [4:0]  rf_rd_addr_o;
    logic [31:0] rf_rd_data_o;
    logic        stall_req_o;
    logic [1:0]  md_fifo_count_o;

    int vectors = 0;
    int miscompares = 0;

    wb_write_arbiter #(.MD_FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .pipe_valid_i   (pipe_valid_i),
        .pipe_rd_addr_i (pipe_rd_addr_i),
        .pipe_rd_data_i (pipe_rd_data_i),
        .md_valid_i     (md_valid_i),
        .md_ready_o     (md_ready_o),
        .md_rd_addr_i   (md_rd_addr_i),
        .md_rd_data_i   (md_rd_data_i),
        .rf_write_en_o  (rf_write_en_o),
        .rf_rd_addr_o   (rf_rd_addr_o),
        .rf_rd_data_o   (rf_rd_data_o),
        .stall_req_o    (stall_req_o),
        .md_fifo_count_o(md_fifo_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pipe(input logic v, input logic [4:0] a, input logic [31:0] d);
        pipe_valid_i   = v;
        pipe_rd_addr_i = a;
        pipe_rd_data_i = d;
    endtask

    task automatic md(input logic v, input logic [4:0] a, input logic [31:0] d);
        md_valid_i   = v;
        md_rd_addr_i = a;
        md_rd_data_i = d;
    endtask

    task automatic chk_wr(input string tag, input logic en, input logic [4:0] a, input logic [31:0] d);
        chk({tag, ".en"}, 32'(rf_write_en_o), 32'(en));
        if (en) begin
            chk({tag, ".addr"}, 32'(rf_rd_addr_o), 32'(a));
            chk({tag, ".data"}, rf_rd_data_o, d);
        end
    endtask

    initial begin
        rst_ni = 1'b0;
        pipe(1'b0, 5'd0, 32'd0);
        md(1'b0, 5'd0, 32'd0);
        tick();
        tick();
        chk("rst.en", 32'(rf_write_en_o), 32'd0);
        chk("rst.addr", 32'(rf_rd_addr_o), 32'd0);
        chk("rst.data", rf_rd_data_o, 32'd0);
        chk("rst.count", 32'(md_fifo_count_o), 32'd0);
        chk("rst.stall", 32'(stall_req_o), 32'd0);
        rst_ni = 1'b1;
        tick();
        chk("rst.ready", 32'(md_ready_o), 32'd1);
        chk_wr("idle", 1'b0, 5'd0, 32'd0);

        // Pipeline write
        pipe(1'b1, 5'd5, 32'hDEAD_BEEF);
        tick();
        chk_wr("pipe5", 1'b1, 5'd5, 32'hDEAD_BEEF);
        pipe(1'b0, 5'd0, 32'd0);
        tick();
        chk_wr("pipe_off", 1'b0, 5'd0, 32'd0);

        // md fall-through
        md(1'b1, 5'd7, 32'h1234);
        chk("ft.ready", 32'(md_ready_o), 32'd1);
        tick();
        chk_wr("ft7", 1'b1, 5'd7, 32'h1234);
        chk("ft.count", 32'(md_fifo_count_o), 32'd0);
        md(1'b0, 5'd0, 32'd0);

        // Fill FIFO while pipeline holds the port
        pipe(1'b1, 5'd3, 32'h3333);
        md(1'b1, 5'd8, 32'h8888);
        tick();
        chk_wr("fill1", 1'b1, 5'd3, 32'h3333);
        chk("fill1.count", 32'(md_fifo_count_o), 32'd1);
        chk("fill1.stall", 32'(stall_req_o), 32'd0);
        md(1'b1, 5'd9, 32'h9999);
        tick();
        chk_wr("fill2", 1'b1, 5'd3, 32'h3333);
        chk("fill2.count", 32'(md_fifo_count_o), 32'd2);
        chk("fill2.ready", 32'(md_ready_o), 32'd0);
        chk("fill2.stall", 32'(stall_req_o), 32'd1);
        pipe(1'b0, 5'd0, 32'd0);
        md(1'b0, 5'd0, 32'd0);
        tick();
        chk_wr("drain8", 1'b1, 5'd8, 32'h8888);
        chk("drain8.count", 32'(md_fifo_count_o), 32'd1);
        chk("drain8.stall", 32'(stall_req_o), 32'd0);
        tick();
        chk_wr("drain9", 1'b1, 5'd9, 32'h9999);
        chk("drain9.count", 32'(md_fifo_count_o), 32'd0);
        tick();
        chk_wr("drained", 1'b0, 5'd0, 32'd0);

        // Starvation: one entry, pipe wins four cycles
        pipe(1'b1, 5'd3, 32'h3333);
        md(1'b1, 5'd10, 32'hAAAA);
        tick();
        md(1'b0, 5'd0, 32'd0);
        chk("st.count", 32'(md_fifo_count_o), 32'd1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("st.lose%0d", i), 32'(stall_req_o), 32'd0);
        end
        tick();
        chk("st.lose4", 32'(stall_req_o), 32'd1);
        chk_wr("st.pipe_wins", 1'b1, 5'd3, 32'h3333);
        pipe(1'b0, 5'd0, 32'd0);
        tick();
        chk_wr("st.deq10", 1'b1, 5'd10, 32'hAAAA);
        chk("st.clear", 32'(stall_req_o), 32'd0);
        tick();
        chk_wr("st.idle", 1'b0, 5'd0, 32'd0);

        // x0 filtering on both sources
        pipe(1'b1, 5'd0, 32'hFFFF_FFFF);
        md(1'b1, 5'd0, 32'h5555);
        chk("x0.ready", 32'(md_ready_o), 32'd1);
        tick();
        chk_wr("x0.a", 1'b0, 5'd0, 32'd0);
        chk("x0.count", 32'(md_fifo_count_o), 32'd0);
        chk("x0.ready2", 32'(md_ready_o), 32'd1);
        pipe(1'b0, 5'd0, 32'd0);
        tick();
        chk_wr("x0.b", 1'b0, 5'd0, 32'd0);
        chk("x0.count2", 32'(md_fifo_count_o), 32'd0);
        md(1'b0, 5'd0, 32'd0);

        // Asynchronous reset with two entries buffered
        pipe(1'b1, 5'd3, 32'h3333);
        md(1'b1, 5'd11, 32'hBBBB);
        tick();
        md(1'b1, 5'd12, 32'hCCCC);
        tick();
        chk("ar.count_pre", 32'(md_fifo_count_o), 32'd2);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("ar.en", 32'(rf_write_en_o), 32'd0);
        chk("ar.addr", 32'(rf_rd_addr_o), 32'd0);
        chk("ar.data", rf_rd_data_o, 32'd0);
        chk("ar.count", 32'(md_fifo_count_o), 32'd0);
        chk("ar.stall", 32'(stall_req_o), 32'd0);
        pipe(1'b0, 5'd0, 32'd0);
        md(1'b0, 5'd0, 32'd0);
        tick();
        rst_ni = 1'b1;
        tick();
        chk_wr("ar.post1", 1'b0, 5'd0, 32'd0);
        chk("ar.post_count", 32'(md_fifo_count_o), 32'd0);
        tick();
        chk_wr("ar.post2", 1'b0, 5'd0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
